// File: rtl/bd2b_sr.sv
// rtl/bd2b_sr.sv - sequential BCD-to-binary converter (reverse double-dabble)
// Shift right one bit per clock and pull every BCD nibble >= 8 back down by 3.
module bd2b_sr #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);
  localparam int W  = 4*DIGITS + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BIN_W);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t           state, state_n;
  logic [W-1:0]     sr, sr_n, corr;
  logic [CW-1:0]    cnt, cnt_n;
  logic             armed, armed_n;
  logic             busy_n, done_n, err_n;
  logic [BIN_W-1:0] bin_n;
  logic             bad;

  // One reverse double-dabble step plus digit validity of the captured operand.
  always_comb begin
    bad  = 1'b0;
    corr = sr >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[BIN_W+4*i +: 4] > 4'd9)
        bad = 1'b1;
      if (corr[BIN_W+4*i +: 4] >= 4'd8)
        corr[BIN_W+4*i +: 4] = corr[BIN_W+4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    armed_n = armed;
    busy_n  = busy;
    done_n  = 1'b0;
    bin_n   = bin;
    err_n   = err;
    case (state)
      IDLE: begin
        if (start) begin
          sr_n    = {bcd, {BIN_W{1'b0}}};
          cnt_n   = CNT_MAX;
          armed_n = 1'b0;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // Digits are validated on the captured register before the first shift.
        if (cnt == CNT_MAX && bad) begin
          armed_n = 1'b1;
          state_n = FINISH;
        end else begin
          sr_n  = corr;
          cnt_n = cnt - CNT_ONE;
          if (cnt == CNT_ONE)
            state_n = FINISH;
        end
      end
      FINISH: begin
        bin_n   = armed ? '0 : sr[BIN_W-1:0];
        err_n   = armed;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      armed <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
      armed <= armed_n;
      busy  <= busy_n;
      done  <= done_n;
      bin   <= bin_n;
      err   <= err_n;
    end
  end
endmodule

// File: tb/tb_bd2b_sr.sv
// tb/tb_bd2b_sr.sv - self-checking bench for bd2b_sr
// Expected results come from decimal arithmetic on the BCD digits.
module tb_bd2b_sr;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] bcd;
  logic        busy, done, err;
  logic [9:0]  bin;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bd2b_sr #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd(bcd),
    .busy(busy), .done(done), .bin(bin), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [11:0] v, output int val, output logic bad, output int lat);
    int nib;
    val = 0;
    bad = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = int'((v >> (4 * d)) & 12'hf);
      if (nib > 9) bad = 1'b1;
      val = val * 10 + nib;
    end
    if (bad) val = 0;
    lat = bad ? 2 : BIN_W + 1;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    logic [11:0] v;
    v[11:8] = 4'(n / 100);
    v[7:4]  = 4'((n / 10) % 10);
    v[3:0]  = 4'(n % 10);
    return v;
  endfunction

  function automatic logic [11:0] rand_bcd(input int bad_rate);
    logic [11:0] v;
    for (int d = 0; d < DIGITS; d++)
      v[4*d +: 4] = ($urandom_range(0, bad_rate - 1) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Issue one conversion and collect what the DUT reports; bcd is scrambled while busy.
  task automatic run(input logic [11:0] v, output int lat, output logic [9:0] b, output logic e,
                     output int busy_cnt, output logic busy_at_done, output logic [11:0] res);
    int c0;
    @(negedge clk);
    bcd   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    bcd      = 12'($urandom);
    c0       = cyc;
    lat      = -1;
    busy_cnt = 0;
    b        = '0;
    e        = 1'b0;
    busy_at_done = 1'b1;
    res      = 12'hfff;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - c0;
        b   = bin;
        e   = err;
        busy_at_done = busy;
        res = dut.sr[21:10];
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bcd = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, bin, err} !== 13'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0", {busy, done, bin, err});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, bin, err} !== 13'd0) begin
      n_fail++; $display("FAIL post_reset_idle: got %b want 0", {busy, done, bin, err});
    end
  endtask

  task automatic test_directed();
    logic [11:0] tbl [5] = '{12'h255, 12'h999, 12'h000, 12'h1A3, 12'h123};
    int lat, bc, ev, el; logic [9:0] b; logic e, bz, eb; logic [11:0] res;
    foreach (tbl[k]) begin
      model(tbl[k], ev, eb, el);
      run(tbl[k], lat, b, e, bc, bz, res);
      n_checks += 5;
      if (lat !== el) begin n_fail++; $display("FAIL dir_latency %h: got %0d want %0d", tbl[k], lat, el); end
      if (b !== 10'(ev)) begin n_fail++; $display("FAIL dir_bin %h: got %0d want %0d", tbl[k], b, ev); end
      if (e !== eb) begin n_fail++; $display("FAIL dir_err %h: got %0d want %0d", tbl[k], e, eb); end
      if (bc !== el) begin n_fail++; $display("FAIL dir_busy_cycles %h: got %0d want %0d", tbl[k], bc, el); end
      if (bz !== 1'b0) begin n_fail++; $display("FAIL dir_busy_with_done %h: got %0d want 0", tbl[k], bz); end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL dir_done_width %h: got %0d want 0", tbl[k], done); end
      if (!eb) begin
        n_checks++;
        if (res !== 12'h000) begin n_fail++; $display("FAIL dir_residual %h: got %h want 000", tbl[k], res); end
      end
    end
  endtask

  task automatic test_start_ignored();
    int c0, lat; logic seen;
    @(negedge clk); bcd = 12'h042; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = cyc;
    repeat (4) @(negedge clk);
    bcd = 12'h500; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin lat = cyc - c0; break; end
    end
    n_checks += 2;
    if (lat !== 11) begin n_fail++; $display("FAIL ign_latency: got %0d want 11", lat); end
    if (bin !== 10'd42) begin n_fail++; $display("FAIL ign_bin: got %0d want 42", bin); end
    bcd = 12'h500; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = cyc; lat = -1; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin lat = cyc - c0; seen = 1'b1; break; end
    end
    n_checks += 2;
    if (lat !== 11) begin n_fail++; $display("FAIL b2b_latency: got %0d want 11 (seen %0d)", lat, seen); end
    if (bin !== 10'd500) begin n_fail++; $display("FAIL b2b_bin: got %0d want 500", bin); end
  endtask

  task automatic test_back_to_back();
    int ev, el, t[$]; logic eb; logic [11:0] v;
    v = rand_bcd(1000);
    model(v, ev, eb, el);
    @(negedge clk); bcd = v; start = 1'b1;
    for (int i = 0; i < 60 && t.size() < 3; i++) begin
      @(negedge clk);
      if (done) begin
        t.push_back(cyc);
        n_checks++;
        if (bin !== 10'(ev)) begin n_fail++; $display("FAIL hold_bin %h: got %0d want %0d", v, bin, ev); end
      end
    end
    start = 1'b0;
    n_checks++;
    if (t.size() !== 3) begin
      n_fail++; $display("FAIL hold_pulses: got %0d want 3", t.size());
    end else begin
      n_checks += 2;
      if (t[1] - t[0] !== BIN_W + 2) begin n_fail++; $display("FAIL hold_period0: got %0d want %0d", t[1] - t[0], BIN_W + 2); end
      if (t[2] - t[1] !== BIN_W + 2) begin n_fail++; $display("FAIL hold_period1: got %0d want %0d", t[2] - t[1], BIN_W + 2); end
    end
    for (int i = 0; i < 30 && (busy || done); i++) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int lat, bc; logic [9:0] b; logic e, bz, seen; logic [11:0] res;
    @(negedge clk); bcd = 12'h777; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, bin, err} !== 13'd0) begin
      n_fail++; $display("FAIL async_reset: got %b want 0", {busy, done, bin, err});
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abandoned_activity: got %0d want 0", seen); end
    run(12'h314, lat, b, e, bc, bz, res);
    n_checks += 3;
    if (lat !== 11) begin n_fail++; $display("FAIL rst_next_latency: got %0d want 11", lat); end
    if (b !== 10'd314) begin n_fail++; $display("FAIL rst_next_bin: got %0d want 314", b); end
    if (e !== 1'b0) begin n_fail++; $display("FAIL rst_next_err: got %0d want 0", e); end
  endtask

  task automatic test_random();
    int lat, bc, ev, el; logic [9:0] b; logic e, bz, eb; logic [11:0] res, v;
    for (int k = 0; k < 300; k++) begin
      v = rand_bcd(6);
      model(v, ev, eb, el);
      run(v, lat, b, e, bc, bz, res);
      n_checks += 3;
      if (lat !== el) begin n_fail++; $display("FAIL rnd_latency %h: got %0d want %0d", v, lat, el); end
      if (b !== 10'(ev)) begin n_fail++; $display("FAIL rnd_bin %h: got %0d want %0d", v, b, ev); end
      if (e !== eb) begin n_fail++; $display("FAIL rnd_err %h: got %0d want %0d", v, e, eb); end
    end
  endtask

  task automatic test_sweep();
    int lat, bc; logic [9:0] b; logic e, bz; logic [11:0] res;
    for (int n = 0; n < 1000; n++) begin
      run(to_bcd(n), lat, b, e, bc, bz, res);
      n_checks += 4;
      if (lat !== 11) begin n_fail++; $display("FAIL sweep_latency %0d: got %0d want 11", n, lat); end
      if (b !== 10'(n)) begin n_fail++; $display("FAIL sweep_bin %0d: got %0d want %0d", n, b, n); end
      if (e !== 1'b0) begin n_fail++; $display("FAIL sweep_err %0d: got %0d want 0", n, e); end
      if (res !== 12'h000) begin n_fail++; $display("FAIL sweep_residual %0d: got %h want 000", n, res); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
